motor_ramp_ctrl: RTL and testbench

Duty-cycle sequencer between the operator switches and the PWM generator in the mini-motor design. Converts a requested duty and direction into a rate-limited duty ramp and passes through zero duty before any direction reversal. Owns overcurrent protection: an overcurrent input forces the motor off, holds it off through a cooldown period, then restarts it with a soft ramp. Exposes state and a fault count for the seven-segment display block.

---
 rtl/motor_ramp_ctrl_if.sv | 26 ++
 rtl/motor_ramp_ctrl.sv | 174 +++++++++++++++++
 tb/tb_motor_ramp_ctrl.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/motor_ramp_ctrl_if.sv
// Signal bundle between the operator/PWM side (master) and motor_ramp_ctrl (slave).
// The master drives duty/direction requests and the raw overcurrent flags.
interface motor_ramp_ctrl_if #(
    parameter int DUTY_W = 7
);
    logic [DUTY_W-1:0] target_duty;
    logic              dir_req;
    logic              oc_set;
    logic              oc_reset;
    logic [DUTY_W-1:0] duty;
    logic              dir;
    logic              motor_en;
    logic              fault;
    logic [1:0]        state;
    logic [3:0]        fault_cnt;

    modport master (
        output target_duty, dir_req, oc_set, oc_reset,
        input  duty, dir, motor_en, fault, state, fault_cnt
    );

    modport slave (
        input  target_duty, dir_req, oc_set, oc_reset,
        output duty, dir, motor_en, fault, state, fault_cnt
    );
endinterface

// File: rtl/motor_ramp_ctrl.sv
// Rate-limited duty sequencer: reversal through zero, overcurrent fault with cooldown.
// Define MOTOR_SOFTSTART_EN for one-LSB-per-tick ramping; otherwise duty jumps to target on a tick.
module motor_ramp_ctrl #(
    parameter int DUTY_W   = 7,
    parameter int STEP_DIV = 1000000,
    parameter int COOLDOWN = 50000000
) (
    input  logic             CLK_100MHz,
    input  logic             RST,
    motor_ramp_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RAMP    = 2'd1,
        REVERSE = 2'd2,
        FAULT   = 2'd3
    } state_e;

    localparam int PRE_W  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int COOL_W = (COOLDOWN > 1) ? $clog2(COOLDOWN + 1) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(STEP_DIV - 1);
    localparam logic [COOL_W-1:0] COOL_LOAD = COOL_W'(COOLDOWN);
    localparam logic [COOL_W-1:0] COOL_ONE  = COOL_W'(1);
    localparam logic [DUTY_W-1:0] DUTY_ONE  = DUTY_W'(1);
    localparam logic [3:0]        CNT_MAX   = 4'hF;

    logic              ocs_meta, ocs, ocr_meta, ocr;
    logic [PRE_W-1:0]  pre_q;
    logic              tick;
    logic              target_nz;

    state_e            state_q, state_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic              dir_q, dir_d;
    logic              motor_en_q, motor_en_d;
    logic              fault_q, fault_d;
    logic [3:0]        fault_cnt_q, fault_cnt_d;
    logic [COOL_W-1:0] cool_q, cool_d;

    logic [DUTY_W-1:0] ramp_duty;      // duty after a RAMP tick with no reversal pending
    logic [DUTY_W-1:0] rev_entry_duty; // duty on the tick that enters REVERSE
    logic [DUTY_W-1:0] rev_exit_duty;  // duty on the tick that leaves REVERSE

    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK_100MHz or posedge RST) begin
        if (RST) begin
            ocs_meta <= 1'b0;
            ocs      <= 1'b0;
            ocr_meta <= 1'b0;
            ocr      <= 1'b0;
        end else begin
            ocs_meta <= bus.oc_set;
            ocs      <= ocs_meta;
            ocr_meta <= bus.oc_reset;
            ocr      <= ocr_meta;
        end
    end

    assign tick = (pre_q == PRE_LAST);

    always_ff @(posedge CLK_100MHz or posedge RST) begin
        if (RST)       pre_q <= '0;
        else if (tick) pre_q <= '0;
        else           pre_q <= pre_q + PRE_W'(1);
    end

    assign target_nz = |bus.target_duty;

`ifdef MOTOR_SOFTSTART_EN
    assign ramp_duty = (duty_q < bus.target_duty) ? duty_q + DUTY_ONE :
                       (duty_q > bus.target_duty) ? duty_q - DUTY_ONE : duty_q;
    assign rev_entry_duty = duty_q;
    assign rev_exit_duty  = '0;
`else
    assign ramp_duty      = bus.target_duty;
    assign rev_entry_duty = '0;
    assign rev_exit_duty  = bus.target_duty;
`endif

    always_ff @(posedge CLK_100MHz or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            duty_q      <= '0;
            dir_q       <= 1'b0;
            motor_en_q  <= 1'b0;
            fault_q     <= 1'b0;
            fault_cnt_q <= '0;
            cool_q      <= '0;
        end else begin
            state_q     <= state_d;
            duty_q      <= duty_d;
            dir_q       <= dir_d;
            motor_en_q  <= motor_en_d;
            fault_q     <= fault_d;
            fault_cnt_q <= fault_cnt_d;
            cool_q      <= cool_d;
        end
    end

    // NOTE: default assignment first so no path through the case leaves state_d unassigned (no latch).
    always_comb begin
        state_d = state_q;
        if (ocs) begin
            state_d = FAULT;
        end else begin
            case (state_q)
                IDLE: begin
                    if (target_nz) state_d = RAMP;
                end
                RAMP: begin
                    if (tick) begin
                        if (bus.dir_req != dir_q)          state_d = REVERSE;
                        else if (duty_q == '0 && !target_nz) state_d = IDLE;
                    end
                end
                REVERSE: begin
                    // Without soft-start duty is already zero here, so the exit tick comes next.
                    if (tick && duty_q == '0) state_d = target_nz ? RAMP : IDLE;
                end
                FAULT: begin
                    if (ocr && cool_q <= COOL_ONE) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        duty_d      = duty_q;
        dir_d       = dir_q;
        cool_d      = cool_q;
        fault_cnt_d = fault_cnt_q;
        if (ocs) begin
            duty_d = '0;
            cool_d = COOL_LOAD;
            if (state_q != FAULT && fault_cnt_q != CNT_MAX) fault_cnt_d = fault_cnt_q + 4'd1;
        end else begin
            case (state_q)
                IDLE: begin
                    duty_d = '0;
                    if (target_nz) dir_d = bus.dir_req;
                end
                RAMP: begin
                    if (tick) duty_d = (bus.dir_req != dir_q) ? rev_entry_duty : ramp_duty;
                end
                REVERSE: begin
                    if (tick) begin
                        if (duty_q != '0) begin
                            duty_d = duty_q - DUTY_ONE;
                        end else begin
                            dir_d  = ~dir_q;
                            duty_d = rev_exit_duty;
                        end
                    end
                end
                FAULT: begin
                    duty_d = '0;
                    if (!ocr)               cool_d = COOL_LOAD;
                    else if (cool_q != '0)  cool_d = cool_q - COOL_ONE;
                end
                default: duty_d = '0;
            endcase
        end
        motor_en_d = (state_d == RAMP) || (state_d == REVERSE);
        fault_d    = (state_d == FAULT);
    end

    assign bus.duty      = duty_q;
    assign bus.dir       = dir_q;
    assign bus.motor_en  = motor_en_q;
    assign bus.fault     = fault_q;
    assign bus.state     = state_q;
    assign bus.fault_cnt = fault_cnt_q;
endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Scoreboard bench for motor_ramp_ctrl: directed test-plan phases plus random traffic,
// predicted cycle by cycle by a behavioural model and compared by an independent monitor.
module tb_motor_ramp_ctrl;
    localparam int DUTY_W   = 7;
    localparam int STEP_DIV = 4;
    localparam int COOLDOWN = 16;
`ifdef MOTOR_SOFTSTART_EN
    localparam bit SOFT = 1'b1;
`else
    localparam bit SOFT = 1'b0;
`endif

    localparam int S_IDLE    = 0;
    localparam int S_RAMP    = 1;
    localparam int S_REVERSE = 2;
    localparam int S_FAULT   = 3;

    typedef struct {
        int duty;
        int dir;
        int motor_en;
        int fault;
        int state;
        int fault_cnt;
    } out_t;

    logic CLK_100MHz = 1'b0;
    logic RST;

    motor_ramp_ctrl_if #(.DUTY_W(DUTY_W)) bus ();

    motor_ramp_ctrl #(
        .DUTY_W  (DUTY_W),
        .STEP_DIV(STEP_DIV),
        .COOLDOWN(COOLDOWN)
    ) dut (
        .CLK_100MHz(CLK_100MHz),
        .RST       (RST),
        .bus       (bus)
    );

    always #5 CLK_100MHz = ~CLK_100MHz;

    int   n_checks = 0;
    int   n_pass   = 0;
    out_t exp_q[$];

    int m_state, m_duty, m_dir, m_fault_cnt, m_run, m_edges;
    int set_hist[$];
    int rel_hist[$];

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: actual %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    endtask

    function automatic void model_clear();
        m_state     = S_IDLE;
        m_duty      = 0;
        m_dir       = 0;
        m_fault_cnt = 0;
        m_run       = 0;
        m_edges     = 0;
        set_hist    = '{0, 0};
        rel_hist    = '{0, 0};
    endfunction

    // Predicts the outputs after the coming clock edge from the inputs now applied.
    function automatic void model_edge();
        int  ocs, ocr, tgt, req;
        bit  tick;
        if (RST) begin
            model_clear();
            return;
        end
        // A level reaches the controller two edges after it is sampled.
        ocs = set_hist.pop_front();
        set_hist.push_back(int'(bus.oc_set));
        ocr = rel_hist.pop_front();
        rel_hist.push_back(int'(bus.oc_reset));
        m_edges++;
        tick = (m_edges % STEP_DIV) == 0;
        tgt  = int'(bus.target_duty);
        req  = int'(bus.dir_req);

        if (ocs != 0) begin
            if (m_state != S_FAULT) m_fault_cnt = (m_fault_cnt < 15) ? m_fault_cnt + 1 : 15;
            m_state = S_FAULT;
            m_duty  = 0;
            m_run   = 0;
        end else if (m_state == S_IDLE) begin
            if (tgt != 0) begin
                m_state = S_RAMP;
                m_dir   = req;
            end
        end else if (m_state == S_RAMP) begin
            if (tick) begin
                if (req != m_dir) begin
                    m_state = S_REVERSE;
                    if (!SOFT) m_duty = 0;
                end else if (m_duty == 0 && tgt == 0) begin
                    m_state = S_IDLE;
                end else if (SOFT) begin
                    if (m_duty < tgt)      m_duty = m_duty + 1;
                    else if (m_duty > tgt) m_duty = m_duty - 1;
                end else begin
                    m_duty = tgt;
                end
            end
        end else if (m_state == S_REVERSE) begin
            if (tick) begin
                if (m_duty > 0) begin
                    m_duty = m_duty - 1;
                end else begin
                    m_dir   = 1 - m_dir;
                    m_state = (tgt != 0) ? S_RAMP : S_IDLE;
                    if (!SOFT) m_duty = tgt;
                end
            end
        end else begin
            // Cooldown: count consecutive below-threshold cycles since the last reload.
            m_run = (ocr != 0) ? m_run + 1 : 0;
            if (m_run >= COOLDOWN) m_state = S_IDLE;
        end
    endfunction

    function automatic out_t model_out();
        out_t o;
        o.duty      = m_duty;
        o.dir       = m_dir;
        o.motor_en  = (m_state == S_RAMP || m_state == S_REVERSE) ? 1 : 0;
        o.fault     = (m_state == S_FAULT) ? 1 : 0;
        o.state     = m_state;
        o.fault_cnt = m_fault_cnt;
        return o;
    endfunction

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            model_edge();
            exp_q.push_back(model_out());
            @(negedge CLK_100MHz);
        end
    endtask

    task automatic check_all_clear(input string tag);
        check({tag, "_duty"},      int'(bus.duty),      0);
        check({tag, "_dir"},       int'(bus.dir),       0);
        check({tag, "_motor_en"},  int'(bus.motor_en),  0);
        check({tag, "_fault"},     int'(bus.fault),     0);
        check({tag, "_state"},     int'(bus.state),     S_IDLE);
        check({tag, "_fault_cnt"}, int'(bus.fault_cnt), 0);
    endtask

    task automatic pulse_oc(input int len, input int after);
        bus.oc_set = 1'b1;
        step(len);
        bus.oc_set = 1'b0;
        step(after);
    endtask

    task automatic random_phase(input int segs);
        int r;
        for (int s = 0; s < segs; s++) begin
            r = int'($urandom_range(0, 7));
            if (r < 3)       bus.target_duty = DUTY_W'($urandom_range(0, 12));
            else if (r == 3) bus.target_duty = '0;
            else if (r == 4) bus.target_duty = '1;
            if ($urandom_range(0, 3) == 0) bus.dir_req = ~bus.dir_req;
            if ($urandom_range(0, 5) == 0) pulse_oc(int'($urandom_range(1, 3)), 0);
            if ($urandom_range(0, 6) == 0) begin
                bus.oc_reset = 1'b0;
                step(int'($urandom_range(1, 6)));
                bus.oc_reset = 1'b1;
            end
            step(int'($urandom_range(4, 40)));
        end
    endtask

    // Monitor: compares every registered output just after each active edge.
    initial begin : monitor
        out_t e;
        forever begin
            @(posedge CLK_100MHz);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("duty",      int'(bus.duty),      e.duty);
                check("dir",       int'(bus.dir),       e.dir);
                check("motor_en",  int'(bus.motor_en),  e.motor_en);
                check("fault",     int'(bus.fault),     e.fault);
                check("state",     int'(bus.state),     e.state);
                check("fault_cnt", int'(bus.fault_cnt), e.fault_cnt);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        RST             = 1'b1;
        bus.target_duty = '0;
        bus.dir_req     = 1'b0;
        bus.oc_set      = 1'b0;
        bus.oc_reset    = 1'b1;
        model_clear();
        @(negedge CLK_100MHz);
        check_all_clear("reset");
        step(2);
        RST = 1'b0;

        // Ramp up to 5 from reset, forward direction.
        bus.target_duty = DUTY_W'(5);
        step(40);
        check("ramp5_duty", int'(bus.duty), 5);
        check("ramp5_state", int'(bus.state), S_RAMP);
        check("ramp5_motor_en", int'(bus.motor_en), 1);

        // Reversal passes through zero and comes back up.
        bus.dir_req = 1'b1;
        step(60);
        check("rev_duty", int'(bus.duty), 5);
        check("rev_dir", int'(bus.dir), 1);
        check("rev_state", int'(bus.state), S_RAMP);

        // Single-cycle overcurrent at duty 3, then cooldown and soft restart.
        bus.target_duty = DUTY_W'(3);
        step(30);
        pulse_oc(1, 40);
        check("oc1_fault_cnt", int'(bus.fault_cnt), 1);
        check("oc1_state", int'(bus.state), S_RAMP);
        check("oc1_duty", int'(bus.duty), 3);

        // oc_reset drops mid-cooldown, forcing a reload.
        pulse_oc(1, 8);
        bus.oc_reset = 1'b0;
        step(5);
        bus.oc_reset = 1'b1;
        step(40);
        check("oc2_fault_cnt", int'(bus.fault_cnt), 2);

        // Counter saturates at 15.
        for (int i = 0; i < 17; i++) pulse_oc(1, 22);
        check("sat_fault_cnt", int'(bus.fault_cnt), 15);

        // Asynchronous reset between clock edges clears everything at once.
        #2 RST = 1'b1;
        #1;
        check_all_clear("async_rst");
        model_clear();
        @(negedge CLK_100MHz);
        step(2);
        RST = 1'b0;

        // Full-scale ramp and return to IDLE.
        bus.target_duty = '1;
        step(127 * STEP_DIV + 8);
        check("full_duty", int'(bus.duty), 127);
        bus.target_duty = '0;
        step(127 * STEP_DIV + 16);
        check("zero_duty", int'(bus.duty), 0);
        check("zero_state", int'(bus.state), S_IDLE);

        random_phase(120);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
